dac_frame_tx: RTL and testbench
===============================

# dac_frame_tx

Multi-channel successor to the single-word DAC parallel-to-serial controller. Accepts channel-tagged samples over a valid/ready stream, buffers them in a small FIFO, and generates its own active-low frame strobe plus serial data at clk_4M rate. Frame length, channel count, bit order and inter-frame gap are parameters. Sits between the sample generators and the external serial DAC pins.

## Interface
- DWIDTH, 8: sample width in bits
- NCH, 2: DAC channel count; ABITS = max(1, clog2(NCH)) address bits
- FIFO_DEPTH, 4: command FIFO entries, power of two, ≥2
- MSB_FIRST, 0: 0 = LSB-first frame, 1 = MSB-first
- GAP, 2: idle cycles with scen_n high between frames, 0..15
- clk_4M  in  1  bit clock; phase is set by the PLL
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  FIFO can accept; equals !full
- in_data  in  DWIDTH  sample
- in_ch  in  ABITS  target channel; values ≥ NCH are accepted, sent as-is
- enable  in  1  permits new frames to start
- scen_n  out  1  frame strobe, low while frame bits are on dout
- dout  out  1  serial data
- busy  out  1  high in SHIFT or GAP
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Frame vector F = {1'b1, in_ch, in_data}, FRAME_LEN = DWIDTH+ABITS+1 bits. LSB-first: data[0] first, G bit (1) last. MSB-first: G bit first, then ch MSB..LSB, then data MSB..LSB.
- Push when in_valid && in_ready. No push when full; source holds data.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: if enable && level≠0, pop FIFO, load shifter, zero bit counter → SHIFT.
  - SHIFT: shift one bit per cycle; after FRAME_LEN cycles → GAP (or IDLE if GAP=0).
  - GAP: count GAP cycles → IDLE.
- enable low blocks only the IDLE→SHIFT transition; the frame in progress and its gap complete.
- Simultaneous push and pop: level unchanged, both take effect; a push into an empty FIFO is not visible to IDLE until the next cycle.
- dout = 0 outside SHIFT; shifter fills with 0.
- Reset, including mid-frame: FSM→IDLE, FIFO emptied, partial frame abandoned, no resumption.

## Timing
- Reset values: scen_n=1, dout=0, busy=0, level=0, in_ready=1.
- All outputs are registered; in_ready is a registered-state decode.
- Pop edge: scen_n falls and the first frame bit is on dout in the same cycle after that edge. scen_n stays low exactly FRAME_LEN cycles, one bit per cycle.
- Back-to-back frame period is FRAME_LEN+GAP+1 cycles (includes one IDLE cycle).
- Push-to-scen_n-fall latency from an empty, idle block is 2 cycles.
- in_ready rises the cycle after the pop that un-fills the FIFO.

## Structure
- Package dac_pkg holds the FSM state enum, the FRAME_LEN/ABITS computation functions, and the bit-order constants.
- Sub-module dac_cmd_fifo holds the synchronous FIFO, width DWIDTH+ABITS, with registered full, empty and level. The top holds the FSM, shifter and counters.

## Test plan
- Defaults; push 0xA5 on ch1 → scen_n low 10 cycles, dout = 1,0,1,0,0,1,0,1,1,1, then scen_n high, dout 0.
- MSB_FIRST=1, same push → dout = 1,1,1,0,1,0,0,1,0,1.
- Push 6 words back-to-back → in_ready drops after 4 are stored; scen_n falls every 13 cycles; all 6 frames are sent in order; level returns to 0.
- enable=0 with 3 words queued → no frame starts and level=3. Raise enable, then drop it mid-frame → that frame plus its 2-cycle gap complete, and no further frame starts.
- Assert rst_n low at bit 4 of a frame with 2 words queued → scen_n=1, dout=0, level=0 immediately; after release nothing is sent.
- GAP=0, NCH=4, DWIDTH=12 → FRAME_LEN=15, period 16 cycles, address bits correct for ch3.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel DAC frame transmitter.
package dac_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } dac_state_t;

    // Bit-order selectors for the MSB_FIRST parameter.
    localparam int unsigned ORDER_LSB_FIRST = 32'd0;
    localparam int unsigned ORDER_MSB_FIRST = 32'd1;

    // Channel address width; a single-channel build still carries one address bit.
    function automatic int unsigned calc_abits(input int unsigned nch);
        int unsigned r;
        r = (nch > 32'd1) ? $clog2(nch) : 32'd1;
        return r;
    endfunction

    // Frame length: data bits, channel address bits and the leading/trailing G bit.
    function automatic int unsigned calc_frame_len(input int unsigned dwidth, input int unsigned nch);
        return dwidth + calc_abits(nch) + 32'd1;
    endfunction

endpackage

// File: rtl/dac_cmd_fifo.sv
// Synchronous command FIFO holding {channel, sample} words. Full, empty and
// level are registers so that downstream decodes stay glitch-free.
module dac_cmd_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_4M,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE_C = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_ZERO_C = (AW+1)'(1'b0);
    localparam logic [AW:0]   CNT_FULL_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             push_s;
    logic             pop_s;

    // A full FIFO ignores writes and an empty one ignores reads.
    assign push_s  = wr_en && !full_r;
    assign pop_s   = rd_en && !empty_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign level   = count_r;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE_C;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk_4M) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk_4M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO_C;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL_C);
            empty_r <= (count_nxt_s == CNT_ZERO_C);
        end
    end

endmodule

// File: rtl/dac_frame_tx.sv
// Multi-channel DAC frame transmitter: queues channel-tagged samples and
// serialises each as {G=1, channel, sample} under an active-low frame strobe.
module dac_frame_tx
    import dac_pkg::*;
#(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned NCH        = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned GAP        = 2
) (
    input  logic                          clk_4M,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DWIDTH-1:0]             in_data,
    input  logic [calc_abits(NCH)-1:0]    in_ch,
    input  logic                          enable,
    output logic                          scen_n,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned ABITS     = calc_abits(NCH);
    localparam int unsigned FRAME_LEN = calc_frame_len(DWIDTH, NCH);
    localparam int unsigned CW        = $clog2(FRAME_LEN + 32'd16);
    localparam logic [CW-1:0] CNT_ONE_C   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO_C  = CW'(1'b0);
    localparam logic [CW-1:0] FRAME_LAST_C = CW'(FRAME_LEN - 32'd1);
    localparam logic [CW-1:0] GAP_LAST_C  = (GAP > 32'd0) ? CW'(GAP - 32'd1) : CW'(1'b0);

    dac_state_t             state_r;
    dac_state_t             state_nxt_s;
    logic [FRAME_LEN-1:0]   shift_r;
    logic [FRAME_LEN-1:0]   shift_nxt_s;
    logic [FRAME_LEN-1:0]   shift_adv_s;
    logic [FRAME_LEN-1:0]   frame_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   scen_n_r;
    logic                   busy_r;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [ABITS+DWIDTH-1:0] fifo_rd_data_s;

    dac_cmd_fifo #(
        .WIDTH (ABITS + DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_4M  (clk_4M),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data ({in_ch, in_data}),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (level)
    );

    // The G bit sits at the top of the frame vector; bit order picks which end leaves first.
    assign frame_s     = {1'b1, fifo_rd_data_s};
    assign shift_adv_s = (MSB_FIRST == ORDER_MSB_FIRST) ? {shift_r[FRAME_LEN-2:0], 1'b0}
                                                        : {1'b0, shift_r[FRAME_LEN-1:1]};
    // The shifter drains to zero, so its output bit is already 0 outside a frame.
    assign dout     = (MSB_FIRST == ORDER_MSB_FIRST) ? shift_r[FRAME_LEN-1] : shift_r[0];
    assign scen_n   = scen_n_r;
    assign busy     = busy_r;
    assign in_ready = !fifo_full_s;

    // Sequencer next-state, pop request, shifter and counter update.
    always_comb begin
        state_nxt_s = state_r;
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && !fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = frame_s;
                    cnt_nxt_s   = CNT_ZERO_C;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_nxt_s = shift_adv_s;
                if (cnt_r == FRAME_LAST_C) begin
                    cnt_nxt_s   = CNT_ZERO_C;
                    state_nxt_s = (GAP == 32'd0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE_C;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST_C) begin
                    cnt_nxt_s   = CNT_ZERO_C;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE_C;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                shift_nxt_s = '0;
                cnt_nxt_s   = CNT_ZERO_C;
            end
        endcase
    end

    // Sequencer registers; strobe and busy are registered from the next state so they align with dout.
    always_ff @(posedge clk_4M or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            shift_r  <= '0;
            cnt_r    <= CNT_ZERO_C;
            scen_n_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            shift_r  <= shift_nxt_s;
            cnt_r    <= cnt_nxt_s;
            scen_n_r <= (state_nxt_s != ST_SHIFT);
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dac_frame_tx.sv
// Bench for dac_frame_tx: three builds (defaults, MSB-first, 12-bit/4-channel/no-gap)
// checked against a frame model derived from the frame-vector rules.
module tb_dac_frame_tx;

    logic clk_4M = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;

    // instance 0: defaults
    logic       a_in_valid = 1'b0, a_in_ready, a_enable = 1'b1, a_scen_n, a_dout, a_busy;
    logic [7:0] a_in_data = 8'd0;
    logic [0:0] a_in_ch = 1'b0;
    logic [2:0] a_level;
    // instance 1: MSB-first
    logic       b_in_valid = 1'b0, b_in_ready, b_enable = 1'b1, b_scen_n, b_dout, b_busy;
    logic [7:0] b_in_data = 8'd0;
    logic [0:0] b_in_ch = 1'b0;
    logic [2:0] b_level;
    // instance 2: DWIDTH=12, NCH=4, GAP=0
    logic        c_in_valid = 1'b0, c_in_ready, c_enable = 1'b1, c_scen_n, c_dout, c_busy;
    logic [11:0] c_in_data = 12'd0;
    logic [1:0]  c_in_ch = 2'd0;
    logic [2:0]  c_level;

    dac_frame_tx u_a (
        .clk_4M(clk_4M), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ch(a_in_ch), .enable(a_enable), .scen_n(a_scen_n),
        .dout(a_dout), .busy(a_busy), .level(a_level));

    dac_frame_tx #(.MSB_FIRST(1)) u_b (
        .clk_4M(clk_4M), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ch(b_in_ch), .enable(b_enable), .scen_n(b_scen_n),
        .dout(b_dout), .busy(b_busy), .level(b_level));

    dac_frame_tx #(.DWIDTH(12), .NCH(4), .GAP(0)) u_c (
        .clk_4M(clk_4M), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_ch(c_in_ch), .enable(c_enable), .scen_n(c_scen_n),
        .dout(c_dout), .busy(c_busy), .level(c_level));

    always #5 clk_4M = ~clk_4M;
    always @(posedge clk_4M) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // model parameters per instance
    int dw_of [3] = '{8, 8, 12};
    int ab_of [3] = '{1, 1, 2};
    int msb_of[3] = '{0, 1, 0};
    int gap_of[3] = '{2, 2, 0};

    // monitor / scoreboard state
    logic        inf[3];
    int          flen[3];
    logic [31:0] cap[3];
    logic [31:0] caps[3][64];
    int          nfr[3];
    int          falls[3][64];
    int          nfalls[3];
    logic [31:0] expf[3][64];
    int          exp_wr[3];
    int          exp_rd[3];
    int          cur_data[3];
    int          cur_ch[3];
    int          last_drive[3];
    logic        prev_rdy[3];
    int          lvl_max[3];
    logic        rdy_low[3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame bits in transmission order (index 0 leaves first), from F = {1, ch, data}.
    function automatic logic [31:0] model_frame(input int k, input int data, input int ch);
        logic [31:0] v;
        logic [31:0] r;
        int fl;
        fl = dw_of[k] + ab_of[k] + 1;
        v = 32'(data & ((1 << dw_of[k]) - 1)) | (32'(ch & ((1 << ab_of[k]) - 1)) << dw_of[k])
            | (32'd1 << (dw_of[k] + ab_of[k]));
        r = 32'd0;
        for (int i = 0; i < fl; i++) r[i] = (msb_of[k] != 0) ? v[fl-1-i] : v[i];
        return r;
    endfunction

    function automatic logic get_scen(input int k);
        case (k) 0: return a_scen_n; 1: return b_scen_n; default: return c_scen_n; endcase
    endfunction
    function automatic logic get_dout(input int k);
        case (k) 0: return a_dout; 1: return b_dout; default: return c_dout; endcase
    endfunction
    function automatic logic get_ready(input int k);
        case (k) 0: return a_in_ready; 1: return b_in_ready; default: return c_in_ready; endcase
    endfunction
    function automatic logic get_valid(input int k);
        case (k) 0: return a_in_valid; 1: return b_in_valid; default: return c_in_valid; endcase
    endfunction
    function automatic int get_level(input int k);
        case (k) 0: return int'(a_level); 1: return int'(b_level); default: return int'(c_level); endcase
    endfunction

    // Negedge monitor: records accepted pushes into the model queue and checks each frame.
    initial begin
        for (int k = 0; k < 3; k++) begin
            inf[k] = 1'b0; flen[k] = 0; cap[k] = 32'd0; nfr[k] = 0; nfalls[k] = 0;
            exp_wr[k] = 0; exp_rd[k] = 0; prev_rdy[k] = 1'b1; lvl_max[k] = 0; rdy_low[k] = 1'b0;
        end
        forever begin
            @(negedge clk_4M);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    inf[k] = 1'b0;
                    prev_rdy[k] = 1'b1;
                end else begin
                    if (get_valid(k) && get_ready(k)) begin
                        expf[k][exp_wr[k] % 64] = model_frame(k, cur_data[k], cur_ch[k]);
                        exp_wr[k]++;
                    end
                    if (!get_scen(k)) begin
                        if (!inf[k]) begin
                            falls[k][nfalls[k] % 64] = cyc;
                            nfalls[k]++;
                            inf[k] = 1'b1; flen[k] = 0; cap[k] = 32'd0;
                            if (!prev_rdy[k]) check_val($sformatf("ready_after_pop%0d", k), 32'(get_ready(k)), 32'd1);
                        end
                        if (flen[k] < 32) cap[k][flen[k]] = get_dout(k);
                        flen[k]++;
                    end else if (inf[k]) begin
                        inf[k] = 1'b0;
                        caps[k][nfr[k] % 64] = cap[k];
                        nfr[k]++;
                        check_val($sformatf("frame_len%0d", k), flen[k], dw_of[k] + ab_of[k] + 1);
                        check_val($sformatf("dout_after%0d", k), 32'(get_dout(k)), 32'd0);
                        check_val($sformatf("frame_expected%0d", k), 32'(exp_rd[k] < exp_wr[k]), 32'd1);
                        if (exp_rd[k] < exp_wr[k]) begin
                            check_val($sformatf("frame_bits%0d", k), cap[k], expf[k][exp_rd[k] % 64]);
                            exp_rd[k]++;
                        end
                    end else begin
                        check_val($sformatf("idle_dout%0d", k), 32'(get_dout(k)), 32'd0);
                    end
                    if (get_level(k) > lvl_max[k]) lvl_max[k] = get_level(k);
                    if (!get_ready(k)) rdy_low[k] = 1'b1;
                    prev_rdy[k] = get_ready(k);
                end
            end
        end
    end

    // Offer one sample and hold it until accepted; returns #1 after the accepting edge.
    task automatic push(input int k, input int d, input int ch);
        int t;
        cur_data[k] = d; cur_ch[k] = ch; last_drive[k] = cyc;
        case (k)
            0: begin a_in_data = d[7:0];  a_in_ch = ch[0:0]; a_in_valid = 1'b1; end
            1: begin b_in_data = d[7:0];  b_in_ch = ch[0:0]; b_in_valid = 1'b1; end
            default: begin c_in_data = d[11:0]; c_in_ch = ch[1:0]; c_in_valid = 1'b1; end
        endcase
        t = 0;
        @(negedge clk_4M);
        while (!get_ready(k) && t < 200) begin @(negedge clk_4M); t++; end
        check_val("push_accept", 32'(get_ready(k)), 32'd1);
        @(posedge clk_4M); #1;
        case (k)
            0: a_in_valid = 1'b0;
            1: b_in_valid = 1'b0;
            default: c_in_valid = 1'b0;
        endcase
    endtask

    task automatic wait_frames(input int k, input int n);
        int t;
        t = 0;
        while (nfr[k] < n && t < 2000) begin @(negedge clk_4M); t++; end
        check_val($sformatf("wait_frames%0d", k), nfr[k], n);
    endtask

    task automatic wait_falls(input int k, input int n);
        int t;
        t = 0;
        while (nfalls[k] < n && t < 2000) begin @(negedge clk_4M); t++; end
        check_val($sformatf("wait_falls%0d", k), nfalls[k], n);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_4M);
    endtask

    task automatic check_periods(input int k, input int s, input int n, input int period);
        for (int i = s + 1; i < s + n; i++)
            check_val($sformatf("period%0d", k), falls[k][i % 64] - falls[k][(i-1) % 64], period);
    endtask

    initial begin
        int s, f, n;
        #1000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, f, n;
        // reset state
        repeat (3) @(negedge clk_4M);
        check_val("rst_scen_n", 32'(a_scen_n), 32'd1);
        check_val("rst_dout", 32'(a_dout), 32'd0);
        check_val("rst_busy", 32'(a_busy), 32'd0);
        check_val("rst_level", 32'(a_level), 32'd0);
        check_val("rst_in_ready", 32'(a_in_ready), 32'd1);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk_4M);
        #1;

        // 0xA5 on ch1, LSB-first, and push-to-strobe latency
        push(0, 32'hA5, 1);
        wait_frames(0, 1);
        check_val("a5_bits", caps[0][0], 32'h3A5);
        check_val("a5_latency", falls[0][0] - last_drive[0], 32'd2);
        repeat (5) @(negedge clk_4M);
        check_val("a5_level", 32'(a_level), 32'd0);

        // back-to-back bursts: first 6 words, then random-length random bursts
        for (int b = 0; b < 4; b++) begin
            n = (b == 0) ? 6 : int'($urandom_range(7, 5));
            s = nfalls[0];
            lvl_max[0] = 0; rdy_low[0] = 1'b0;
            @(posedge clk_4M); #1;
            for (int i = 0; i < n; i++) push(0, int'($urandom_range(255, 0)), int'($urandom_range(1, 0)));
            wait_frames(0, nfr[0] + (s + n - nfalls[0]) + (nfalls[0] - nfr[0]));
            check_val("burst_level_peak", lvl_max[0], 32'd4);
            check_val("burst_ready_dropped", 32'(rdy_low[0]), 32'd1);
            check_periods(0, s, n, 13);
            repeat (3) @(negedge clk_4M);
            check_val("burst_level_end", 32'(a_level), 32'd0);
        end

        // enable low holds queued words; a frame started before enable drops completes with its gap
        a_enable = 1'b0;
        s = nfalls[0];
        @(posedge clk_4M); #1;
        for (int i = 0; i < 3; i++) push(0, int'($urandom_range(255, 0)), int'($urandom_range(1, 0)));
        repeat (30) @(negedge clk_4M);
        check_val("hold_level", 32'(a_level), 32'd3);
        check_val("hold_nofall", nfalls[0], s);
        check_val("hold_busy", 32'(a_busy), 32'd0);
        a_enable = 1'b1;
        wait_falls(0, s + 1);
        f = falls[0][s % 64];
        wait_cyc(f + 5);
        a_enable = 1'b0;
        wait_cyc(f + 11);
        check_val("gap_busy", 32'(a_busy), 32'd1);
        wait_cyc(f + 12);
        check_val("idle_busy", 32'(a_busy), 32'd0);
        repeat (40) @(negedge clk_4M);
        check_val("drop_nofall", nfalls[0], s + 1);
        check_val("drop_level", 32'(a_level), 32'd2);
        a_enable = 1'b1;
        wait_frames(0, nfalls[0] + 2);
        check_periods(0, s + 1, 2, 13);
        repeat (3) @(negedge clk_4M);
        check_val("drain_level", 32'(a_level), 32'd0);

        // MSB-first build
        @(posedge clk_4M); #1;
        push(1, 32'hA5, 1);
        wait_frames(1, 1);
        check_val("msb_a5_bits", caps[1][0], 32'h297);
        @(posedge clk_4M); #1;
        for (int i = 0; i < 3; i++) push(1, int'($urandom_range(255, 0)), int'($urandom_range(1, 0)));
        wait_frames(1, 4);
        check_periods(1, 1, 3, 13);

        // 12-bit, 4-channel, gapless build
        @(posedge clk_4M); #1;
        push(2, int'($urandom_range(4095, 0)), 3);
        push(2, int'($urandom_range(4095, 0)), 3);
        push(2, int'($urandom_range(4095, 0)), int'($urandom_range(3, 0)));
        wait_frames(2, 3);
        check_val("c_ch3_bits", 32'(caps[2][0][13:12]), 32'd3);
        check_val("c_g_bit", 32'(caps[2][0][14]), 32'd1);
        check_periods(2, 0, 3, 16);

        // reset at bit 4 of a frame with 2 words queued
        a_enable = 1'b0;
        s = nfalls[0];
        @(posedge clk_4M); #1;
        for (int i = 0; i < 3; i++) push(0, int'($urandom_range(255, 0)), int'($urandom_range(1, 0)));
        a_enable = 1'b1;
        wait_falls(0, s + 1);
        f = falls[0][s % 64];
        wait_cyc(f + 4);
        check_val("pre_rst_level", 32'(a_level), 32'd2);
        #1 rst_n = 1'b0;
        exp_rd[0] = exp_wr[0];
        #1;
        check_val("midrst_scen_n", 32'(a_scen_n), 32'd1);
        check_val("midrst_dout", 32'(a_dout), 32'd0);
        check_val("midrst_level", 32'(a_level), 32'd0);
        check_val("midrst_busy", 32'(a_busy), 32'd0);
        check_val("midrst_in_ready", 32'(a_in_ready), 32'd1);
        repeat (3) @(negedge clk_4M);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk_4M);
        check_val("post_rst_nofall", nfalls[0], s + 1);
        check_val("post_rst_level", 32'(a_level), 32'd0);
        check_val("post_rst_scen_n", 32'(a_scen_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
